// File: rtl/nn_pkg.sv
// Shared fixed-point constants and layer-pass state encoding for the neuron pipeline blocks.
package nn_pkg;

  localparam int DATA_W           = 16;
  localparam int FRAC_W           = 8;
  localparam logic [15:0] Q_MAX   = 16'h7FFF;
  localparam logic [15:0] Q_MIN   = 16'h8000;
  localparam int DEFAULT_PIPE_LAT = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/valid_delay_line.sv
// 1-bit tag shift register: din reappears on dout DEPTH cycles later; clear empties it.
// No backpressure: one tag shifts in every cycle.
module valid_delay_line #(
  parameter int DEPTH = 11
) (
  input  logic clk,
  input  logic clear,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (clear) sr <= '0;
        else       sr <= din;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (clear) sr <= '0;
        else       sr <= {sr[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/neuron_post_stage.sv
// Bias add, saturate, optional ReLU and running argmax on dot-product results; result lands one
// cycle after its tap, done one cycle later. Issues are throttled only by issue_ready.
module neuron_post_stage
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_W      = nn_pkg::DATA_W,
  parameter int PIPE_LAT    = DEFAULT_PIPE_LAT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          relu_en,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [DATA_W-1:0]             acc_in,
  input  logic [NUM_NEURONS*DATA_W-1:0] bias_in,
  output logic [NUM_NEURONS*DATA_W-1:0] act_out,
  output logic [3:0]                    class_idx,
  output logic [DATA_W-1:0]             class_max,
  output logic                          busy,
  output logic                          done
);

  localparam int CNT_W = $clog2(NUM_NEURONS + 1);
  localparam logic [CNT_W-1:0]  NUM_C   = CNT_W'(NUM_NEURONS);
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t state, state_nxt;

  logic [CNT_W-1:0]              issue_cnt;
  logic [CNT_W-1:0]              res_cnt;
  logic                          relu_q;
  logic [NUM_NEURONS*DATA_W-1:0] act_q;
  logic [3:0]                    idx_q;
  logic [DATA_W-1:0]             max_q;

  logic              launch;
  logic              accept;
  logic              tap;
  logic              res_vld;
  logic [DATA_W-1:0] bias_sel;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] act_val;
  logic              take_max;

  assign launch  = (state == IDLE) && start;
  assign accept  = issue_valid && issue_ready;
  assign res_vld = tap && ((state == ISSUE) || (state == DRAIN)) && (res_cnt < NUM_C);

  // Tags travel alongside the upstream pipeline so each result is tied to its issue slot.
  valid_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_valid_delay_line (
    .clk   (clk),
    .clear (reset || launch),
    .din   (accept),
    .dout  (tap)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    issue_ready = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy        = 1'b1;
        issue_ready = (issue_cnt < NUM_C);
        if (issue_cnt == NUM_C) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (res_cnt == NUM_C) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bias_sel = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (res_cnt == CNT_W'(n)) bias_sel = bias_in[n*DATA_W +: DATA_W];
    end
  end

  // One guard bit catches overflow of the Q8.8 add; disagreeing top bits mean saturate.
  always_comb begin
    sum = {acc_in[DATA_W-1], acc_in} + {bias_sel[DATA_W-1], bias_sel};
    if (sum[DATA_W] != sum[DATA_W-1]) act_val = sum[DATA_W] ? SAT_MIN : SAT_MAX;
    else                              act_val = sum[DATA_W-1:0];
    if (relu_q && act_val[DATA_W-1]) act_val = '0;
    take_max = (res_cnt == '0) || ($signed(act_val) > $signed(max_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt <= '0;
      res_cnt   <= '0;
      relu_q    <= 1'b0;
      act_q     <= '0;
      idx_q     <= '0;
      max_q     <= SAT_MIN;
    end else if (launch) begin
      issue_cnt <= '0;
      res_cnt   <= '0;
      relu_q    <= relu_en;
      idx_q     <= '0;
      max_q     <= SAT_MIN;
    end else begin
      if (accept) issue_cnt <= issue_cnt + 1'b1;
      if (res_vld) begin
        res_cnt <= res_cnt + 1'b1;
        for (int n = 0; n < NUM_NEURONS; n++) begin
          if (res_cnt == CNT_W'(n)) act_q[n*DATA_W +: DATA_W] <= act_val;
        end
        if (take_max) begin
          idx_q <= 4'(res_cnt);
          max_q <= act_val;
        end
      end
    end
  end

  assign act_out   = act_q;
  assign class_idx = idx_q;
  assign class_max = max_q;

endmodule

// File: tb/tb_neuron_post_stage.sv
// Directed bench: an upstream model replays per-neuron acc values PIPE_LAT cycles after accept.
module tb_neuron_post_stage;

  localparam int NN = 10;
  localparam int DW = 16;
  localparam int PL = 11;

  typedef logic [DW-1:0] tab_t [NN];

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             relu_en;
  logic             issue_valid;
  logic             issue_ready;
  logic [DW-1:0]    acc_in;
  logic [NN*DW-1:0] bias_in;
  logic [NN*DW-1:0] act_out;
  logic [3:0]       class_idx;
  logic [DW-1:0]    class_max;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  neuron_post_stage #(
    .NUM_NEURONS (NN),
    .DATA_W      (DW),
    .PIPE_LAT    (PL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .relu_en     (relu_en),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .acc_in      (acc_in),
    .bias_in     (bias_in),
    .act_out     (act_out),
    .class_idx   (class_idx),
    .class_max   (class_max),
    .busy        (busy),
    .done        (done)
  );

  // Upstream pipeline model: value of the k-th accepted issue emerges PL cycles later.
  tab_t          acc_tab;
  logic [DW-1:0] up_dat [PL];
  logic [PL-1:0] up_vld = '0;
  int            cyc = 0;
  int            acc_n = 0;
  int            res_seen = 0;
  int            last_acc_cyc = 0;
  logic          tb_clr;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    up_vld <= {up_vld[PL-2:0], issue_valid && issue_ready};
    up_dat[0] <= (acc_n < NN) ? acc_tab[acc_n] : '0;
    for (int i = 1; i < PL; i++) up_dat[i] <= up_dat[i-1];
    if (tb_clr) begin
      acc_n    <= 0;
      res_seen <= 0;
    end else begin
      if (issue_valid && issue_ready) begin
        acc_n        <= acc_n + 1;
        last_acc_cyc <= cyc;
      end
      if (up_vld[PL-1]) res_seen <= res_seen + 1;
    end
  end

  assign acc_in = up_vld[PL-1] ? up_dat[PL-1] : 16'h5A5A;

  task automatic chk(input string tag, input logic [NN*DW-1:0] got, input logic [NN*DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NN*DW-1:0] pack(input tab_t t);
    logic [NN*DW-1:0] r;
    for (int n = 0; n < NN; n++) r[n*DW +: DW] = t[n];
    return r;
  endfunction

  task automatic run_pass(input string nm, input logic relu, input int gap, input bit hold,
                          input tab_t ex, input logic [3:0] ex_idx, input logic [DW-1:0] ex_max);
    int lat;
    int ready_bad;
    @(negedge clk);
    tb_clr  = 1'b1;
    start   = 1'b1;
    relu_en = relu;
    @(negedge clk);
    tb_clr  = 1'b0;
    start   = 1'b0;
    relu_en = ~relu;
    chk({nm, "_busy_issue"}, {159'd0, busy}, 160'd1);
    for (int i = 0; i < NN; i++) begin
      issue_valid = 1'b1;
      @(negedge clk);
      if (gap > 0) begin
        issue_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    issue_valid = hold;
    lat = -1;
    ready_bad = 0;
    for (int c = 0; c < 100 && lat < 0; c++) begin
      if (issue_ready) ready_bad++;
      if (done) lat = cyc - last_acc_cyc - 1;
      else @(negedge clk);
    end
    chk({nm, "_done_lat"}, 160'(lat), 160'd12);
    chk({nm, "_act"}, act_out, pack(ex));
    chk({nm, "_idx"}, 160'(class_idx), 160'(ex_idx));
    chk({nm, "_max"}, 160'(class_max), 160'(ex_max));
    chk({nm, "_accepts"}, 160'(acc_n), 160'(NN));
    chk({nm, "_ready_after_issue"}, 160'(ready_bad), 160'd0);
    @(negedge clk);
    chk({nm, "_done_pulse"}, {159'd0, done}, 160'd0);
    chk({nm, "_busy_end"}, {159'd0, busy}, 160'd0);
    issue_valid = 1'b0;
    relu_en     = 1'b0;
  endtask

  tab_t btab;
  tab_t ex;

  initial begin
    int done_seen;
    reset = 1'b1; start = 1'b0; relu_en = 1'b0; issue_valid = 1'b0; tb_clr = 1'b1;
    for (int n = 0; n < NN; n++) begin acc_tab[n] = '0; btab[n] = '0; end
    bias_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_act", act_out, '0);
    chk("rst_idx", 160'(class_idx), 160'd0);
    chk("rst_max", 160'(class_max), 160'h8000);
    chk("rst_ctl", {156'd0, busy, done, issue_ready, 1'b0}, 160'd0);
    reset = 1'b0; tb_clr = 1'b0;
    @(negedge clk);

    // 1: ramp, back-to-back
    for (int n = 0; n < NN; n++) begin
      acc_tab[n] = 16'(n * 256); btab[n] = 16'h0000; ex[n] = 16'(n * 256);
    end
    bias_in = pack(btab);
    run_pass("t1", 1'b0, 0, 1'b0, ex, 4'd9, 16'h0900);

    // 2: saturation both ways, plus near-limit values that must not saturate
    for (int n = 0; n < NN; n++) begin acc_tab[n] = '0; btab[n] = '0; ex[n] = '0; end
    acc_tab[0] = 16'h7F00; btab[0] = 16'h0200; ex[0] = 16'h7FFF;
    acc_tab[1] = 16'h8100; btab[1] = 16'hFE00; ex[1] = 16'h8000;
    acc_tab[2] = 16'h0100; btab[2] = 16'hFF80; ex[2] = 16'h0080;
    acc_tab[3] = 16'h8000; btab[3] = 16'h0001; ex[3] = 16'h8001;
    bias_in = pack(btab);
    run_pass("t2", 1'b0, 0, 1'b0, ex, 4'd0, 16'h7FFF);

    // 3: ReLU with every sum negative
    for (int n = 0; n < NN; n++) begin acc_tab[n] = 16'hFF00; btab[n] = '0; ex[n] = '0; end
    btab[5] = 16'h0080;
    bias_in = pack(btab);
    run_pass("t3", 1'b1, 0, 1'b0, ex, 4'd0, 16'h0000);

    // 4: tie between neurons 3 and 7 keeps the lower index
    for (int n = 0; n < NN; n++) begin
      acc_tab[n] = 16'(n * 16); btab[n] = '0; ex[n] = 16'(n * 16);
    end
    acc_tab[3] = 16'h0400; btab[3] = 16'h0100; ex[3] = 16'h0500;
    acc_tab[7] = 16'h0600; btab[7] = 16'hFF00; ex[7] = 16'h0500;
    bias_in = pack(btab);
    run_pass("t4", 1'b0, 0, 1'b0, ex, 4'd3, 16'h0500);

    // 5: gapped issues, issue_valid held through drain, descending results
    for (int n = 0; n < NN; n++) begin
      acc_tab[n] = 16'(16'h0200 - n * 32); btab[n] = 16'h0100; ex[n] = 16'(16'h0300 - n * 32);
    end
    bias_in = pack(btab);
    run_pass("t5", 1'b0, 2, 1'b1, ex, 4'd0, 16'h0300);

    // 6: reset after four results
    for (int n = 0; n < NN; n++) begin acc_tab[n] = 16'(n * 256); btab[n] = 16'h0010; end
    bias_in = pack(btab);
    for (int n = 0; n < 4; n++) ex[n] = 16'(n * 256 + 16);
    @(negedge clk);
    tb_clr = 1'b1; start = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0; start = 1'b0; issue_valid = 1'b1;
    repeat (NN) @(negedge clk);
    issue_valid = 1'b0;
    for (int c = 0; c < 40 && res_seen < 4; c++) @(negedge clk);
    chk("t6_four_results", 160'(res_seen), 160'd4);
    chk("t6_partial_act", act_out, pack(ex));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rst_act", act_out, '0);
    chk("t6_rst_max", 160'(class_max), 160'h8000);
    chk("t6_rst_ctl", {156'd0, busy, done, issue_ready, 1'b0}, 160'd0);
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk("t6_no_done", 160'(done_seen), 160'd0);
    for (int n = 0; n < NN; n++) begin
      acc_tab[n] = 16'(n * 256); btab[n] = 16'h0000; ex[n] = 16'(n * 256);
    end
    bias_in = pack(btab);
    run_pass("t6_fresh", 1'b0, 0, 1'b0, ex, 4'd9, 16'h0900);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
